fp_add_normalize: RTL and testbench

Post-add normalisation, rounding and pack stage of the floating-point ALU. It sits directly downstream of the adder pipeline stage and consumes that stage's registered 25-bit magnitude sum, biased exponent and result sign. It normalises the magnitude iteratively, one bit per cycle, using a small FSM, then packs an IEEE-754 single-precision word. A valid/ready handshake on both sides absorbs the variable latency.

---
 rtl/fp_add_normalize.sv | 159 +++++++++++++++
 tb/tb_fp_add_normalize.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalize.sv
// Post-add normalise/round/pack stage: iterative one-bit-per-cycle normaliser feeding an IEEE-754 single word.
// Define FP_NORM_ROUND_EN to round-to-nearest-even on the bit dropped by the carry right shift.
module fp_add_normalize (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] sum_in,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        zero
);

    typedef enum logic [1:0] {IDLE, RSHIFT, NORM, DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [24:0] r_mant, w_mant_nxt;
    logic [8:0]  r_exp, w_exp_nxt;
    logic        r_sgn, w_sgn_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic [31:0] r_result, w_result_nxt;
    logic        r_overflow, w_overflow_nxt;
    logic        r_underflow, w_underflow_nxt;
    logic        r_zero, w_zero_nxt;

    logic [23:0] w_rmant;
    logic [8:0]  w_rexp;

`ifdef FP_NORM_ROUND_EN
    logic        w_rnd;
    logic [24:0] w_rsum;

    assign w_rnd   = r_mant[1] & r_mant[0];
    assign w_rsum  = {1'b0, r_mant[24:1]} + {24'd0, w_rnd};
    // A rounding carry-out can only produce exactly 2.0, i.e. 1.0 with one more exponent step
    assign w_rmant = w_rsum[24] ? 24'h800000 : w_rsum[23:0];
    assign w_rexp  = r_exp + (w_rsum[24] ? 9'd2 : 9'd1);
`else
    assign w_rmant = r_mant[24:1];
    assign w_rexp  = r_exp + 9'd1;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign zero      = r_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mant      <= '0;
            r_exp       <= '0;
            r_sgn       <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mant      <= w_mant_nxt;
            r_exp       <= w_exp_nxt;
            r_sgn       <= w_sgn_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_result    <= w_result_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
            r_zero      <= w_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mant_nxt      = r_mant;
        w_exp_nxt       = r_exp;
        w_sgn_nxt       = r_sgn;
        w_out_valid_nxt = r_out_valid;
        w_result_nxt    = r_result;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_zero_nxt      = r_zero;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_mant_nxt = sum_in;
                    w_exp_nxt  = {1'b0, exp_in};
                    w_sgn_nxt  = sign_in;
                    if (exp_in == 8'hFF) begin
                        w_result_nxt    = {sign_in, 8'hFF, 23'd0};
                        w_overflow_nxt  = 1'b1;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = DONE;
                    end else if (sum_in == 25'd0) begin
                        w_sgn_nxt       = 1'b0;
                        w_result_nxt    = 32'h0000_0000;
                        w_zero_nxt      = 1'b1;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = DONE;
                    end else if (sum_in[24]) begin
                        w_state_nxt = RSHIFT;
                    end else begin
                        w_state_nxt = NORM;
                    end
                end
            end

            RSHIFT: begin
                w_mant_nxt      = {1'b0, w_rmant};
                w_exp_nxt       = w_rexp;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = DONE;
                if (w_rexp >= 9'd255) begin
                    w_result_nxt   = {r_sgn, 8'hFF, 23'd0};
                    w_overflow_nxt = 1'b1;
                end else begin
                    w_result_nxt = {r_sgn, w_rexp[7:0], w_rmant[22:0]};
                end
            end

            NORM: begin
                // Hidden one is tested before the exponent floor, so exp == 1 still packs if normalised
                if (r_mant[23]) begin
                    w_result_nxt    = {r_sgn, r_exp[7:0], r_mant[22:0]};
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else if (r_exp == 9'd1) begin
                    w_result_nxt    = {r_sgn, 31'd0};
                    w_underflow_nxt = 1'b1;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end else begin
                    w_mant_nxt = {r_mant[23:0], 1'b0};
                    w_exp_nxt  = r_exp - 9'd1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_overflow_nxt  = 1'b0;
                    w_underflow_nxt = 1'b0;
                    w_zero_nxt      = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Self-checking bench for fp_add_normalize: directed test-plan vectors plus randomized traffic
// checked against a leading-zero-count reference model; honours FP_NORM_ROUND_EN like the design.
module tb_fp_add_normalize;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] sum_in;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        zero;

`ifdef FP_NORM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zro;
        logic [7:0]  lat;
    } expT;

    expT  expQ[$];
    int   acceptCyc[$];
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatch = 0;
    bit   firstSeen = 1'b0;
    int   readyMode = 0;

    fp_add_normalize dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: value-level view of the result; lat counts edges from the one before acceptance
    function automatic expT model(input logic [24:0] s, input logic [7:0] e, input logic sg);
        expT         x;
        logic [24:0] m;
        logic [8:0]  ee;
        int          n;
        x = '0;
        if (e == 8'hFF) begin
            x.res = {sg, 8'hFF, 23'd0};
            x.ovf = 1'b1;
            x.lat = 8'd1;
        end else if (s == 25'd0) begin
            x.zro = 1'b1;
            x.lat = 8'd1;
        end else if (s[24]) begin
            m  = (s >> 1) + ((ROUND && s[1] && s[0]) ? 25'd1 : 25'd0);
            ee = {1'b0, e} + 9'd1;
            if (m[24]) begin
                m  = m >> 1;
                ee = ee + 9'd1;
            end
            x.lat = 8'd2;
            if (ee >= 9'd255) begin
                x.res = {sg, 8'hFF, 23'd0};
                x.ovf = 1'b1;
            end else begin
                x.res = {sg, ee[7:0], m[22:0]};
            end
        end else begin
            n = 0;
            while (n < 23 && !s[23 - n]) n++;
            if (int'(e) > n) begin
                m     = s << n;
                x.res = {sg, e - 8'(n), m[22:0]};
                x.lat = 8'(2 + n);
            end else begin
                x.res = {sg, 31'd0};
                x.unf = 1'b1;
                x.lat = e + 8'd1;
            end
        end
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Single compare process: every cycle a result is presented it must match the queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    checkOutput("result", result, expQ[0].res);
                    checkOutput("overflow", {31'd0, overflow}, {31'd0, expQ[0].ovf});
                    checkOutput("underflow", {31'd0, underflow}, {31'd0, expQ[0].unf});
                    checkOutput("zero", {31'd0, zero}, {31'd0, expQ[0].zro});
                    checkOutput("in_ready_done", {31'd0, in_ready}, 32'd0);
                    if (!firstSeen) begin
                        checkOutput("latency", cyc - acceptCyc[0], {24'd0, expQ[0].lat});
                        firstSeen = 1'b1;
                    end
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        void'(acceptCyc.pop_front());
                        firstSeen = 1'b0;
                    end
                end
            end else if (expQ.size() != 0 && cyc > acceptCyc[0]) begin
                checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        expQ.delete();
        acceptCyc.delete();
        firstSeen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic startTxn(input logic [24:0] s, input logic [7:0] e, input logic sg);
        int t;
        @(negedge clk);
        sum_in   = s;
        exp_in   = e;
        sign_in  = sg;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            doReset();
        end else begin
            expQ.push_back(model(s, e, sg));
            acceptCyc.push_back(cyc);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDone();
        int t;
        t = 0;
        while (expQ.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (expQ.size() != 0) begin
            checkOutput("result_timeout", expQ.size(), 32'd0);
            doReset();
        end
    endtask

    task automatic applyStimulus(input logic [24:0] s, input logic [7:0] e, input logic sg);
        startTxn(s, e, sg);
        waitDone();
    endtask

    task automatic pinModel(input string name, input logic [24:0] s, input logic [7:0] e,
                            input logic sg, input logic [31:0] res, input logic [3:0] flags,
                            input logic [7:0] lat);
        expT x;
        x = model(s, e, sg);
        checkOutput({"model_", name}, x.res, res);
        checkOutput({"model_flags_", name}, {29'd0, x.ovf, x.unf, x.zro}, {28'd0, flags});
        checkOutput({"model_lat_", name}, {24'd0, x.lat}, {24'd0, lat});
    endtask

    initial begin
        logic [24:0] s;
        logic [7:0]  e;
        int          kind;
        int          pos;
        int          t;

        reset    = 1'b1;
        in_valid = 1'b0;
        sum_in   = '0;
        exp_in   = '0;
        sign_in  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_flags", {29'd0, overflow, underflow, zero}, 32'd0);
        reset = 1'b0;

        pinModel("norm", 25'h0800000, 8'd127, 1'b0, 32'h3F800000, 4'b000, 8'd2);
        pinModel("carry", 25'h1000000, 8'd127, 1'b0, 32'h40000000, 4'b000, 8'd2);
        pinModel("carry_rnd", 25'h1000003, 8'd127, 1'b0,
                 ROUND ? 32'h40000002 : 32'h40000001, 4'b000, 8'd2);
        pinModel("deep", 25'h0000001, 8'd127, 1'b1, 32'hB4000000, 4'b000, 8'd25);
        pinModel("uflow", 25'h0000001, 8'd10, 1'b0, 32'h00000000, 4'b010, 8'd11);
        pinModel("oflow", 25'h1FFFFFF, 8'd254, 1'b0, 32'h7F800000, 4'b100, 8'd2);
        pinModel("zero", 25'h0000000, 8'd50, 1'b1, 32'h00000000, 4'b001, 8'd1);

        readyMode = 0;
        applyStimulus(25'h0800000, 8'd127, 1'b0);
        applyStimulus(25'h1000000, 8'd127, 1'b0);
        applyStimulus(25'h1000003, 8'd127, 1'b0);
        applyStimulus(25'h0000001, 8'd127, 1'b1);
        applyStimulus(25'h0000001, 8'd10, 1'b0);
        applyStimulus(25'h1FFFFFF, 8'd254, 1'b0);
        applyStimulus(25'h0123456, 8'hFF, 1'b1);
        applyStimulus(25'h0000100, 8'd1, 1'b1);
        applyStimulus(25'h0800001, 8'd1, 1'b0);

        // Backpressure: hold the zero result for three extra cycles, then release
        readyMode = 2;
        startTxn(25'h0000000, 8'd77, 1'b1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (3) @(negedge clk);
        readyMode = 0;
        waitDone();
        @(negedge clk);
        checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a long normalisation
        startTxn(25'h0000001, 8'd127, 1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        expQ.delete();
        acceptCyc.delete();
        firstSeen = 1'b0;
        @(negedge clk);
        checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        applyStimulus(25'h0800000, 8'd127, 1'b0);

        readyMode = 1;
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            e = 8'($urandom_range(0, 3) == 0 ? $urandom_range(1, 24) : $urandom_range(1, 254));
            if (kind == 0) begin
                s = 25'($urandom);
                e = 8'hFF;
            end else if (kind == 1) begin
                s = 25'd0;
            end else if (kind <= 3) begin
                s = {1'b1, 24'($urandom)};
                if ($urandom_range(0, 4) == 0) e = 8'($urandom_range(250, 254));
            end else begin
                pos = $urandom_range(0, 23);
                s = (25'd1 << pos) | (25'($urandom) & ((25'd1 << pos) - 25'd1));
            end
            applyStimulus(s, e, 1'($urandom_range(0, 1)));
        end

        readyMode = 0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
